// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit add-shift signed multiplier: clears A/X, runs N
// add/sub-then-shift pairs driven by the multiplier LSB, then holds the product.
module mult_control #(
  parameter int N = 8
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_En,
  output logic Load_En,
  output logic Shift_En,
  output logic Add_En,
  output logic Sub_En,
  output logic Busy,
  output logic Done
);

  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOADB,
    CLR,
    ADD,
    SHIFT,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    Clr_En   = 1'b0;
    Load_En  = 1'b0;
    Shift_En = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Run wins over a simultaneous load request.
        if (Run)               state_d = CLR;
        else if (ClearA_LoadB) state_d = LOADB;
      end
      LOADB: begin
        Clr_En  = 1'b1;
        Load_En = 1'b1;
        if (!ClearA_LoadB) state_d = IDLE;
      end
      CLR: begin
        Clr_En  = 1'b1;
        Busy    = 1'b1;
        cnt_d   = '0;
        state_d = ADD;
      end
      ADD: begin
        Busy = 1'b1;
        // The sign bit of the multiplier carries negative weight: subtract on the last bit.
        Add_En  = M && (cnt_q != LAST_BIT);
        Sub_En  = M && (cnt_q == LAST_BIT);
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = ADD;
        end
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: cycle-by-cycle comparison against a
// step-count reference model, directed scenarios, and a behavioural multiplier datapath.
module tb_mult_control;

  localparam int N       = 8;
  localparam int P_LOADB = -2;
  localparam int P_IDLE  = -1;
  localparam int P_HOLD  = 2 * N + 1;

  logic Clk = 1'b0;
  logic Reset_n, Run, ClearA_LoadB, M;
  logic Clr_En, Load_En, Shift_En, Add_En, Sub_En, Busy, Done;
  logic [6:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  logic       m_sel, m_const;
  logic [7:0] sw, a_reg, b_reg;
  logic       x_reg;

  int phase = P_IDLE;
  int add_cnt, sub_cnt, shift_cnt, load_cnt;

  mult_control #(.N(N)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_En       (Clr_En),
    .Load_En      (Load_En),
    .Shift_En     (Shift_En),
    .Add_En       (Add_En),
    .Sub_En       (Sub_En),
    .Busy         (Busy),
    .Done         (Done)
  );

  always #5 Clk = ~Clk;

  assign M    = m_sel ? b_reg[0] : m_const;
  assign outs = {Clr_En, Load_En, Shift_En, Add_En, Sub_En, Busy, Done};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a run is a linear step count 0..2N (0 = clear, odd = add bit, even = shift).
  function automatic int next_phase(input int ph, input logic run, input logic ld);
    if (ph == P_IDLE)  return run ? 0 : (ld ? P_LOADB : P_IDLE);
    if (ph == P_LOADB) return ld ? P_LOADB : P_IDLE;
    if (ph == P_HOLD)  return run ? P_HOLD : P_IDLE;
    if (ph == 2 * N)   return P_HOLD;
    return ph + 1;
  endfunction

  // Output order: {clr, load, shift, add, sub, busy, done}
  function automatic logic [6:0] exp_outs(input int ph, input logic m);
    int b;
    if (ph == P_LOADB) return 7'b1100000;
    if (ph == 0)       return 7'b1000010;
    if (ph == P_HOLD)  return 7'b0000001;
    if (ph >= 1 && ph <= 2 * N) begin
      if (ph % 2 == 0) return 7'b0010010;
      b = (ph - 1) / 2;
      return {3'b000, m && (b < N - 1), m && (b == N - 1), 2'b10};
    end
    return 7'b0000000;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) phase <= P_IDLE;
    else          phase <= next_phase(phase, Run, ClearA_LoadB);
  end

  always @(negedge Clk) begin
    check_eq("outs", 32'(outs), 32'(exp_outs(phase, M)));
    if (Add_En)   add_cnt++;
    if (Sub_En)   sub_cnt++;
    if (Shift_En) shift_cnt++;
    if (Load_En)  load_cnt++;
  end

  // Behavioural X:A:B datapath; S is taken from the switches during the run.
  always @(posedge Clk) begin
    logic [8:0] r;
    if (Clr_En) begin
      a_reg <= '0;
      x_reg <= 1'b0;
      if (Load_En) b_reg <= sw;
    end else if (Add_En || Sub_En) begin
      r = Add_En ? ({a_reg[7], a_reg} + {sw[7], sw}) : ({a_reg[7], a_reg} - {sw[7], sw});
      a_reg <= r[7:0];
      x_reg <= r[8];
    end else if (Shift_En) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  task automatic tick();
    @(negedge Clk);
    #2;
  endtask

  task automatic clear_counts();
    add_cnt = 0; sub_cnt = 0; shift_cnt = 0; load_cnt = 0;
  endtask

  // Full run with constant M: pulse counts, Done latency, hold and release.
  task automatic run_seq(input logic mv, input string tag);
    int  lat;
    bit  got;
    m_sel = 1'b0; m_const = mv;
    clear_counts();
    Run = 1'b1;
    @(posedge Clk);
    lat = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge Clk);
      lat++;
      #1 if (Done) got = 1'b1;
    end
    check_eq({tag, "_done_seen"}, 32'(got), 32'd1);
    check_eq({tag, "_done_lat"}, 32'(lat), 32'(2 * N + 1));
    check_eq({tag, "_adds"}, 32'(add_cnt), mv ? 32'(N - 1) : 32'd0);
    check_eq({tag, "_subs"}, 32'(sub_cnt), mv ? 32'd1 : 32'd0);
    check_eq({tag, "_shifts"}, 32'(shift_cnt), 32'(N));
    repeat (3) tick();
    check_eq({tag, "_hold"}, 32'(Done), 32'd1);
    Run = 1'b0;
    @(posedge Clk);
    #1 check_eq({tag, "_release"}, 32'({Done, Busy}), 32'd0);
    tick();
  endtask

  task automatic do_mult(input logic [7:0] s, input logic [7:0] b);
    int  p;
    bit  got;
    m_sel = 1'b1;
    sw = b; ClearA_LoadB = 1'b1;
    tick();
    ClearA_LoadB = 1'b0;
    tick();
    sw = s; Run = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (Done) got = 1'b1;
    end
    check_eq("mult_done", 32'(got), 32'd1);
    p = int'($signed(s)) * int'($signed(b));
    check_eq("product", 32'({a_reg, b_reg}), 32'(p[15:0]));
    Run = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    bit found;
    Reset_n = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b0;
    m_sel = 1'b0; m_const = 1'b0; sw = '0;
    clear_counts();
    #1 Reset_n = 1'b0;

    // Reset held with Run asserted, then release straight into a run
    repeat (3) begin
      @(negedge Clk);
      #1 check_eq("rst_outs", 32'(outs), 32'd0);
    end
    #1 Reset_n = 1'b1;
    tick();
    check_eq("clr_after_rst", 32'({Clr_En, Load_En, Busy}), 32'b101);
    Run = 1'b0;
    repeat (2 * N + 4) tick();

    // Single and sustained load requests
    clear_counts();
    ClearA_LoadB = 1'b1; tick();
    ClearA_LoadB = 1'b0; repeat (3) tick();
    check_eq("load_1", 32'(load_cnt), 32'd1);
    clear_counts();
    ClearA_LoadB = 1'b1; repeat (4) tick();
    ClearA_LoadB = 1'b0; repeat (3) tick();
    check_eq("load_4", 32'(load_cnt), 32'd4);

    run_seq(1'b1, "m1");
    run_seq(1'b0, "m0");

    // Run and load together: run wins, and load stays ignored through the run
    clear_counts();
    m_const = 1'b1; Run = 1'b1; ClearA_LoadB = 1'b1;
    tick();
    check_eq("both_clr", 32'({Clr_En, Load_En}), 32'b10);
    repeat (2 * N + 3) tick();
    Run = 1'b0; ClearA_LoadB = 1'b0;
    repeat (2) tick();
    check_eq("both_no_load", 32'(load_cnt), 32'd0);

    // Asynchronous reset during the 4th shift
    m_const = 1'b1; Run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (phase == 8) found = 1'b1;
    end
    check_eq("shift4_reached", 32'(found), 32'd1);
    Reset_n = 1'b0;
    #1 check_eq("async_rst", 32'(outs), 32'd0);
    Run = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    run_seq(1'b1, "after_rst");

    // Products through the behavioural datapath
    do_mult(8'h07, 8'hFE);
    for (int i = 0; i < 20; i++) do_mult(8'($urandom), 8'($urandom));

    // Random control traffic with occasional asynchronous resets
    m_sel = 1'b0;
    for (int i = 0; i < 400; i++) begin
      Run          = ($urandom_range(0, 3) != 0);
      ClearA_LoadB = ($urandom_range(0, 2) == 0);
      m_const      = 1'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        Reset_n = 1'b0;
        #1 check_eq("rand_rst", 32'(outs), 32'd0);
        tick();
        Reset_n = 1'b1;
      end
      tick();
    end

    Run = 1'b0; ClearA_LoadB = 1'b0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
